mostra_sequencia: RTL

Sequence presenter for the memory game. It is the transmit side of the play/compare datapath: it walks the sequence ROM from address 0 up to a selected limit and shows each stored value on the LEDs for a fixed on-time, each followed by a blank gap. It then pulses done, so the control unit can move on to collecting player moves. The ROM is external: the sync_rom_16x4 instance, with 1-cycle read latency, is shared with the compare datapath through the control unit's mux.

---
 rtl/mostra_sequencia_pkg.sv | 22 ++
 rtl/mostra_sequencia_temporizador.sv | 25 ++
 rtl/mostra_sequencia.sv | 114 +++++++++++
 3 files changed

// File: rtl/mostra_sequencia_pkg.sv
// Shared definitions for the sequence presenter: state codes shown on db_estado
// and a helper that sizes the phase timer.
package mostra_sequencia_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        LE      = 4'd2,
        ACENDE  = 4'd3,
        APAGA   = 4'd4,
        PROXIMO = 4'd5,
        FIM     = 4'd6
    } estado_t;

    // Bits needed to hold the terminal count (max-1) of the longer phase.
    function automatic int tempo_largura(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mostra_sequencia_temporizador.sv
// Phase timer: counts 0..i_ultimo while enabled and flags the terminal count.
module mostra_sequencia_temporizador #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_limpa,
    input  logic         i_habilita,
    input  logic [W-1:0] i_ultimo,
    output logic         o_fim
);

    logic [W-1:0] r_contagem;

    assign o_fim = i_habilita && (r_contagem == i_ultimo);

    always_ff @(posedge clock) begin
        if (reset || i_limpa) begin
            r_contagem <= '0;
        end else if (i_habilita) begin
            r_contagem <= o_fim ? '0 : r_contagem + 1'b1;
        end
    end

endmodule

// File: rtl/mostra_sequencia.sv
// Sequence presenter: walks the ROM from 0 to the captured limit, lighting each
// value for T_ON cycles followed by T_OFF dark cycles, then pulses pronto.
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] rom_dado,
    output logic [3:0] rom_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int W = tempo_largura(T_ON, T_OFF);
    localparam logic [W-1:0] C_ULT_ON  = W'(T_ON - 1);
    localparam logic [W-1:0] C_ULT_OFF = W'(T_OFF - 1);

    estado_t    r_estado;
    logic [3:0] r_endereco;
    logic [3:0] r_limite;
    logic [3:0] r_leds;
    logic       r_ocupado;
    logic       r_pronto;

    logic         w_fim;
    logic         w_limpa;
    logic         w_habilita;
    logic [W-1:0] w_ultimo;

    // One timer serves both phases; it restarts when a value is loaded and
    // again at the end of the lit phase so the dark phase starts from zero.
    assign w_habilita = (r_estado == ACENDE) || (r_estado == APAGA);
    assign w_limpa    = (r_estado == LE) || ((r_estado == ACENDE) && w_fim);
    assign w_ultimo   = (r_estado == ACENDE) ? C_ULT_ON : C_ULT_OFF;

    mostra_sequencia_temporizador #(
        .W (W)
    ) u_temporizador (
        .clock      (clock),
        .reset      (reset),
        .i_limpa    (w_limpa),
        .i_habilita (w_habilita),
        .i_ultimo   (w_ultimo),
        .o_fim      (w_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_endereco <= 4'd0;
            r_limite   <= 4'd0;
            r_leds     <= 4'd0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                INICIAL: begin
                    r_endereco <= 4'd0;
                    r_leds     <= 4'd0;
                    if (iniciar) begin
                        r_limite  <= limite;
                        r_ocupado <= 1'b1;
                        r_estado  <= CARREGA;
                    end
                end
                CARREGA: r_estado <= LE;
                LE: begin
                    r_leds   <= rom_dado;
                    r_estado <= ACENDE;
                end
                ACENDE: begin
                    if (w_fim) begin
                        r_leds   <= 4'd0;
                        r_estado <= APAGA;
                    end
                end
                APAGA: begin
                    if (w_fim) r_estado <= PROXIMO;
                end
                PROXIMO: begin
                    // Compare before increment so limite=15 never wraps the address.
                    if (r_endereco == r_limite) begin
                        r_pronto <= 1'b1;
                        r_estado <= FIM;
                    end else begin
                        r_endereco <= r_endereco + 4'd1;
                        r_estado   <= CARREGA;
                    end
                end
                FIM: begin
                    r_endereco <= 4'd0;
                    r_ocupado  <= 1'b0;
                    r_estado   <= INICIAL;
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign rom_endereco = r_endereco;
    assign leds         = r_leds;
    assign ocupado      = r_ocupado;
    assign pronto       = r_pronto;
    assign db_estado    = r_estado;

endmodule
